onchip_memory_mp: RTL and testbench

ONCHIP_MEMORY_MP -- requirements
Module: onchip_memory_mp

---
 rtl/onchip_memory_mp_pkg.sv | 15 +
 rtl/onchip_memory_mp_arb.sv | 39 +++
 rtl/onchip_memory_mp.sv | 177 +++++++++++++++++
 tb/tb_onchip_memory_mp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_mp_pkg.sv
// Shared defaults and the log2 helper for the multi-port on-chip memory.
package onchip_memory_mp_pkg;
  localparam int    DEF_DATA_W       = 32;
  localparam int    DEF_DEPTH        = 8192;
  localparam int    DEF_NUM_PORTS    = 2;
  localparam int    DEF_READ_LATENCY = 1;
  localparam string DEF_INIT_FILE    = "onchip_memory_mp.hex";

  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/onchip_memory_mp_arb.sv
// Round-robin arbiter: grants the first requester after the last accepted port.
module onchip_memory_mp_arb
  import onchip_memory_mp_pkg::*;
#(
  parameter int N  = DEF_NUM_PORTS,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [IW-1:0] o_grant,
  output logic          o_any
);
  logic [IW-1:0] r_last;
  int            w_best;
  int            w_dist;

  // Cyclic distance from the port after r_last; smallest distance wins.
  always_comb begin
    o_grant = r_last;
    o_any   = 1'b0;
    w_best  = N;
    w_dist  = 0;
    for (int p = 0; p < N; p++) begin
      w_dist = (p + N - 1 - int'(r_last)) % N;
      if (i_req[p] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = IW'(p);
        o_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_last <= IW'(N - 1);
    else if (i_advance) r_last <= o_grant;
  end
endmodule

// File: rtl/onchip_memory_mp.sv
// NUM_PORTS Avalon-MM slaves arbitrated round-robin onto one byte-enabled RAM.
// Define ONCHIP_MEMORY_MP_CLEAR_EN to zero the array after reset before accepting traffic.
module onchip_memory_mp
  import onchip_memory_mp_pkg::*;
#(
  parameter int    DATA_W       = DEF_DATA_W,
  parameter int    DEPTH        = DEF_DEPTH,
  parameter int    NUM_PORTS    = DEF_NUM_PORTS,
  parameter int    READ_LATENCY = DEF_READ_LATENCY,
  parameter string INIT_FILE    = DEF_INIT_FILE,
  localparam int   ADDR_W       = log2c(DEPTH),
  localparam int   NB           = DATA_W / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reset_req,
  input  logic                             clken,
  input  logic [NUM_PORTS-1:0]             chipselect,
  input  logic [NUM_PORTS-1:0]             read,
  input  logic [NUM_PORTS-1:0]             write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] address,
  input  logic [NUM_PORTS-1:0][NB-1:0]     byteenable,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] writedata,
  output logic [NUM_PORTS-1:0]             waitrequest,
  output logic [NUM_PORTS-1:0]             readdatavalid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] readdata,
  output logic                             init_done
);
  localparam int IDX_W = (NUM_PORTS > 1) ? log2c(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt_oh;
  logic [NUM_PORTS-1:0] w_rd_oh;
  logic [IDX_W-1:0]     w_grant;
  logic                 w_any;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_wr_sel;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [ADDR_W-1:0]    w_addr;
  logic [NB-1:0]        w_be;
  logic [DATA_W-1:0]    w_wdata;

  // The preload image is attached by the device programming flow; RTL only carries its name.
  logic w_unused_init;
  assign w_unused_init = (INIT_FILE != "");

  assign w_req    = chipselect & (read | write);
  assign w_stall  = ~clken | reset_req | ~init_done;
  assign w_accept = w_any & ~w_stall;

  onchip_memory_mp_arb #(
    .N  (NUM_PORTS),
    .IW (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (reset),
    .i_req     (w_req),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_any     (w_any)
  );

  always_comb begin
    w_gnt_oh = '0;
    w_addr   = '0;
    w_be     = '0;
    w_wdata  = '0;
    w_wr_sel = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_gnt_oh[p] = w_any && (w_grant == IDX_W'(p));
      if (w_gnt_oh[p]) begin
        w_addr   = address[p];
        w_be     = byteenable[p];
        w_wdata  = writedata[p];
        w_wr_sel = write[p];
      end
    end
  end

  // Read+write together is a write.
  assign w_wr_acc    = w_accept & w_wr_sel;
  assign w_rd_acc    = w_accept & ~w_wr_sel;
  assign w_rd_oh     = w_gnt_oh & {NUM_PORTS{w_rd_acc}};
  assign waitrequest = w_req & ~(w_gnt_oh & {NUM_PORTS{~w_stall}});

  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              r_init;

`ifdef ONCHIP_MEMORY_MP_CLEAR_EN
  logic [ADDR_W-1:0] r_sweep;

  assign w_sweep_we   = ~r_init & ~reset_req & ~reset;
  assign w_sweep_addr = r_sweep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep <= '0;
      r_init  <= 1'b0;
    end else if (w_sweep_we) begin
      r_sweep <= r_sweep + 1'b1;
      if (r_sweep == ADDR_W'(DEPTH - 1)) r_init <= 1'b1;
    end
  end
`else
  assign w_sweep_we   = 1'b0;
  assign w_sweep_addr = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_init <= 1'b0;
    else       r_init <= 1'b1;
  end
`endif

  assign init_done = r_init;

  // Single write port (sweep or granted write) and single read port; never both in one cycle.
  logic [NB-1:0][7:0] r_mem [DEPTH];
  logic [DATA_W-1:0]  r_q;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [NB-1:0]      w_mem_be;
  logic [DATA_W-1:0]  w_mem_wdata;

  assign w_mem_we    = w_sweep_we | w_wr_acc;
  assign w_mem_addr  = w_sweep_we ? w_sweep_addr : w_addr;
  assign w_mem_be    = w_sweep_we ? '1 : w_be;
  assign w_mem_wdata = w_sweep_we ? '0 : w_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we)
      for (int b = 0; b < NB; b++)
        if (w_mem_be[b]) r_mem[w_mem_addr][b] <= w_mem_wdata[b*8 +: 8];
    if (w_rd_acc) r_q <= r_mem[w_addr];
  end

  logic [READ_LATENCY:1][NUM_PORTS-1:0] vld_pipe;
  logic [DATA_W-1:0]                    w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= w_rd_oh;
      for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] r_q2;
      always_ff @(posedge clk) begin
        if (vld_pipe[1] != '0) r_q2 <= r_q;
      end
      assign w_rdata = r_q2;
    end else begin : g_lat1
      assign w_rdata = r_q;
    end
  endgenerate

  logic [NUM_PORTS-1:0][DATA_W-1:0] r_hold;

  assign readdatavalid = vld_pipe[READ_LATENCY];

  always_comb begin
    readdata = r_hold;
    for (int p = 0; p < NUM_PORTS; p++)
      if (readdatavalid[p]) readdata[p] = w_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hold <= '0;
    else       r_hold <= readdata;
  end
endmodule

// File: tb/tb_onchip_memory_mp.sv
// Checks onchip_memory_mp at read latency 1 and 2 against a transaction-level memory model.
module tb_onchip_memory_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NP    = 2;
  localparam int AW    = 4;
  localparam int NB    = 4;
`ifdef ONCHIP_MEMORY_MP_CLEAR_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset, reset_req, clken;
  logic [NP-1:0]            cs, rd, wr;
  logic [NP-1:0][AW-1:0]    addr;
  logic [NP-1:0][NB-1:0]    be;
  logic [NP-1:0][DW-1:0]    wdata;
  logic [NP-1:0]            wait1, rdv1, wait2, rdv2;
  logic [NP-1:0][DW-1:0]    rdata1, rdata2;
  logic                     idone1, idone2;

  onchip_memory_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_PORTS(NP), .READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(cs), .read(rd), .write(wr), .address(addr), .byteenable(be), .writedata(wdata),
    .waitrequest(wait1), .readdatavalid(rdv1), .readdata(rdata1), .init_done(idone1));

  onchip_memory_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_PORTS(NP), .READ_LATENCY(2), .INIT_FILE("")) u_dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(cs), .read(rd), .write(wr), .address(addr), .byteenable(be), .writedata(wdata),
    .waitrequest(wait2), .readdatavalid(rdv2), .readdata(rdata2), .init_done(idone2));

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0]         mem [DEPTH];
  rd_t                   pq [2][$];
  logic [NP-1:0][DW-1:0] h [2];
  int                    last_g, cyc;
  bit                    m_init;
  logic [AW-1:0]         sweep;
  int                    n_assert, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model.
  task automatic cycle();
    logic [NP-1:0] req, wexp;
    logic [NP-1:0] vexp [2];
    int            g;
    bit            stall, acc, s_wr;
    logic [AW-1:0] s_addr;
    logic [NB-1:0] s_be;
    logic [DW-1:0] s_wd;
    rd_t           r;
    #1;
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        pq[l].delete();
        h[l] = '0;
      end
      last_g = NP - 1;
      m_init = 1'b0;
      sweep  = '0;
    end
    req   = cs & (rd | wr);
    stall = !clken || reset_req || !m_init;
    g     = -1;
    for (int k = 1; k <= NP; k++)
      for (int p = 0; p < NP; p++)
        if (g < 0 && p == (last_g + k) % NP && req[p]) g = p;
    acc    = (g >= 0) && !stall;
    wexp   = req;
    s_wr   = 1'b0;
    s_addr = '0;
    s_be   = '0;
    s_wd   = '0;
    for (int p = 0; p < NP; p++)
      if (p == g) begin
        if (acc) wexp[p] = 1'b0;
        s_wr = wr[p]; s_addr = addr[p]; s_be = be[p]; s_wd = wdata[p];
      end
    for (int l = 0; l < 2; l++) begin
      vexp[l] = '0;
      if (pq[l].size() > 0 && pq[l][0].due == cyc) begin
        r = pq[l].pop_front();
        for (int p = 0; p < NP; p++)
          if (p == r.port) begin
            vexp[l][p] = 1'b1;
            h[l][p]    = r.data;
          end
      end
    end
    chk("init_done_l1", 64'(idone1), 64'(m_init));
    chk("init_done_l2", 64'(idone2), 64'(m_init));
    chk("waitrequest_l1", 64'(wait1), 64'(wexp));
    chk("waitrequest_l2", 64'(wait2), 64'(wexp));
    chk("readdatavalid_l1", 64'(rdv1), 64'(vexp[0]));
    chk("readdatavalid_l2", 64'(rdv2), 64'(vexp[1]));
    chk("readdata_l1", 64'(rdata1), 64'(h[0]));
    chk("readdata_l2", 64'(rdata2), 64'(h[1]));
    if (!reset) begin
      if (acc) begin
        if (s_wr) begin
          for (int b = 0; b < NB; b++)
            if (s_be[b]) mem[s_addr][8*b +: 8] = s_wd[8*b +: 8];
        end else begin
          pq[0].push_back('{cyc + 1, g, mem[s_addr]});
          pq[1].push_back('{cyc + 2, g, mem[s_addr]});
        end
        last_g = g;
      end
`ifdef ONCHIP_MEMORY_MP_CLEAR_EN
      if (!m_init && !reset_req) begin
        mem[sweep] = '0;
        if (sweep == AW'(DEPTH - 1)) m_init = 1'b1;
        sweep = sweep + 1'b1;
      end
`else
      m_init = 1'b1;
`endif
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cs = '0; rd = '0; wr = '0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic drive(input int p, input bit w, input logic [AW-1:0] a,
                       input logic [NB-1:0] b, input logic [DW-1:0] d);
    for (int q = 0; q < NP; q++)
      if (q == p) begin
        cs[q] = 1'b1; rd[q] = !w; wr[q] = w; addr[q] = a; be[q] = b; wdata[q] = d;
      end
  endtask

  task automatic wait_init();
    int n = 0;
    while (idone1 !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("init_latency", 64'(n), 64'(INIT_CYC));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v0, v1;
    n_assert = 0; n_fail = 0; cyc = 0; last_g = NP - 1; m_init = 1'b0; sweep = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    h[0] = '0; h[1] = '0;
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
`ifdef ONCHIP_MEMORY_MP_CLEAR_EN
    drive(0, 1'b0, 4'd3, 4'h0, 32'h0);
    wait_init();
    cycle();
    idle();
    chk("sweep_read_vld", 64'(rdv1), 64'(2'b01));
    chk("sweep_read_zero", 64'(rdata1[0]), 64'(32'h0));
    cycle();
    cycle();
`else
    wait_init();
`endif

    for (int a = 0; a < DEPTH; a++) begin
      idle();
      drive(0, 1'b1, AW'(a), 4'hF, $urandom);
      cycle();
    end

    idle(); drive(0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF); cycle();
    idle(); drive(0, 1'b0, 4'd5, 4'h0, 32'h0); cycle();
    idle();
    chk("wr_then_rd_vld_l1", 64'(rdv1), 64'(2'b01));
    chk("wr_then_rd_data_l1", 64'(rdata1[0]), 64'(32'hDEADBEEF));
    cycle();
    chk("wr_then_rd_vld_l2", 64'(rdv2), 64'(2'b01));
    chk("wr_then_rd_data_l2", 64'(rdata2[0]), 64'(32'hDEADBEEF));
    cycle();

    idle(); drive(0, 1'b1, 4'd7, 4'hF, 32'h11223344); cycle();
    idle(); drive(1, 1'b1, 4'd7, 4'b0101, 32'hAABBCCDD); cycle();
    idle(); drive(0, 1'b0, 4'd7, 4'h0, 32'h0); cycle();
    idle();
    chk("byteen_merge_l1", 64'(rdata1[0]), 64'(32'h11BB33DD));
    cycle();
    cycle();

    idle();
    drive(0, 1'b0, 4'd1, 4'h0, 32'h0);
    drive(1, 1'b0, 4'd2, 4'h0, 32'h0);
    v0 = 0; v1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wait_complementary", 64'(wait1[0] ^ wait1[1]), 64'd1);
      cycle();
      if (rdv1[0]) v0++;
      if (rdv1[1]) v1++;
    end
    idle();
    chk("rr_valids_p0", 64'(v0), 64'd4);
    chk("rr_valids_p1", 64'(v1), 64'd4);
    cycle();
    cycle();

    idle(); drive(1, 1'b0, 4'd7, 4'h0, 32'h0); cycle();
    chk("clken_lat1_vld", 64'(rdv1), 64'(2'b10));
    clken = 1'b0;
    drive(0, 1'b0, 4'd3, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("clken_low_wait", 64'(wait1), 64'(2'b11));
      cycle();
      if (i == 0) begin
        chk("clken_lat2_vld", 64'(rdv2), 64'(2'b10));
        chk("clken_lat2_data", 64'(rdata2[1]), 64'(32'h11BB33DD));
      end
    end
    clken = 1'b1;
    idle();
    cycle();
    cycle();

    idle(); drive(0, 1'b0, 4'd5, 4'h0, 32'h0); cycle();
    idle();
    reset = 1'b1;
    cycle();
    chk("rst_drop_vld_l2", 64'(rdv2), 64'(2'b00));
    chk("rst_rdata_l1", 64'(rdata1), 64'(0));
    cycle();
    reset = 1'b0;
    wait_init();
    drive(0, 1'b0, 4'd1, 4'h0, 32'h0);
    drive(1, 1'b0, 4'd2, 4'h0, 32'h0);
    #1;
    chk("post_rst_grant_p0", 64'(wait1), 64'(2'b10));
    cycle();
    idle();
    cycle();
    cycle();

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        cs[p]    = ($urandom_range(0, 3) != 0);
        rd[p]    = 1'($urandom_range(0, 1));
        wr[p]    = ($urandom_range(0, 2) == 0);
        addr[p]  = AW'($urandom_range(0, DEPTH - 1));
        be[p]    = NB'($urandom);
        wdata[p] = $urandom;
      end
      clken     = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();
    clken = 1'b1;
    reset_req = 1'b0;
    cycle();
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
